// File: rtl/popcnt_cmp_sched_if.sv
// Request/operand and grant/result bundle between the requesters and the
// shared set-bit comparator scheduler.
interface popcnt_cmp_sched_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [1:0]             result;

    modport master (
        output req, a_in, b_in,
        input  grant, busy, done, done_id, result
    );

    modport slave (
        input  req, a_in, b_in,
        output grant, busy, done, done_id, result
    );
endinterface

// File: rtl/popcnt_cmp_sched.sv
// Round-robin arbiter in front of one serial popcount comparator: capture a
// winner's operands, count set bits one per cycle, report gt/lt/eq with its id.
module popcnt_cmp_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    popcnt_cmp_sched_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d, last_id_q, last_id_d;
    logic [ID_W-1:0]  done_id_q, done_id_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [1:0]       result_q, result_d;

    logic             win_vld;
    logic [ID_W-1:0]  win_id;
    int               idx;

    function automatic logic [1:0] cmp(input logic [CW-1:0] a, input logic [CW-1:0] b);
        if (a > b)      return 2'b01;
        else if (a < b) return 2'b10;
        else            return 2'b00;
    endfunction

    // Scan upward from the requester after the last winner, wrapping around.
    always_comb begin : arb
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_id_q) + k) % N_REQ;
            if (!win_vld && bus.req[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin : fsm
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        bitcnt_d  = bitcnt_q;
        cur_id_d  = cur_id_q;
        last_id_d = last_id_q;
        done_id_d = done_id_q;
        result_d  = result_q;
        grant_d   = '0;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    sa_d     = bus.a_in[win_id*WIDTH +: WIDTH];
                    sb_d     = bus.b_in[win_id*WIDTH +: WIDTH];
                    cnt_a_d  = '0;
                    cnt_b_d  = '0;
                    bitcnt_d = '0;
                    cur_id_d = win_id;
                    grant_d  = N_REQ'(1) << win_id;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                cnt_a_d  = cnt_a_q + CW'(sa_q[0]);
                cnt_b_d  = cnt_b_q + CW'(sb_q[0]);
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                bitcnt_d = bitcnt_q + CW'(1);
                // The verdict uses the counts including this last bit, so done
                // rises together with entry into DONE.
                if (bitcnt_q == CW'(WIDTH - 1)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    result_d  = cmp(cnt_a_d, cnt_b_d);
                    done_id_d = cur_id_q;
                    last_id_d = cur_id_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            cnt_a_q   <= '0;
            cnt_b_q   <= '0;
            bitcnt_q  <= '0;
            cur_id_q  <= '0;
            last_id_q <= ID_W'(N_REQ - 1);
            done_id_q <= '0;
            result_q  <= 2'b00;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            cnt_a_q   <= cnt_a_d;
            cnt_b_q   <= cnt_b_d;
            bitcnt_q  <= bitcnt_d;
            cur_id_q  <= cur_id_d;
            last_id_q <= last_id_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.result  = result_q;
endmodule

// File: tb/tb_popcnt_cmp_sched.sv
// Directed bench for popcnt_cmp_sched: fixed-latency comparisons, boundaries,
// round-robin order, operand capture and asynchronous reset mid-comparison.
module tb_popcnt_cmp_sched;
    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   exp_g [7] = '{0, 2, 0, 2, 0, 1, 2};

    always #5 clk = ~clk;

    popcnt_cmp_sched_if #(.N_REQ(N), .WIDTH(W)) bus_if ();

    popcnt_cmp_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of cycle 10.
    task automatic run_cmp(input string tag, input int port, input logic [7:0] a,
                           input logic [7:0] b, input logic [1:0] exp_res);
        bus_if.a_in[port*W +: W] = a;
        bus_if.b_in[port*W +: W] = b;
        bus_if.req = 4'b0001 << port;
        @(negedge clk);
        chk($sformatf("%s_grant", tag), 32'(bus_if.grant), 32'(1) << port);
        chk($sformatf("%s_busy", tag), 32'(bus_if.busy), 32'd1);
        bus_if.req = '0;
        repeat (7) @(negedge clk);
        chk($sformatf("%s_done_early", tag), 32'(bus_if.done), 32'd0);
        @(negedge clk);
        chk($sformatf("%s_done", tag), 32'(bus_if.done), 32'd1);
        chk($sformatf("%s_done_id", tag), 32'(bus_if.done_id), 32'(port));
        chk($sformatf("%s_result", tag), 32'(bus_if.result), 32'(exp_res));
        @(negedge clk);
        chk($sformatf("%s_idle", tag), {30'd0, bus_if.busy, bus_if.done}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        bus_if.req  = '0;
        bus_if.a_in = '0;
        bus_if.b_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 32'(bus_if.grant), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_done_id", 32'(bus_if.done_id), 32'd0);
        chk("rst_result", 32'(bus_if.result), 32'd0);
        rst_n = 1'b1;

        run_cmp("p0_64_31", 0, 8'd64, 8'd31, 2'b10);
        run_cmp("p1_21_129", 1, 8'd21, 8'd129, 2'b01);
        run_cmp("p1_224_7", 1, 8'd224, 8'd7, 2'b00);
        run_cmp("p1_9_2", 1, 8'd9, 8'd2, 2'b01);
        run_cmp("p3_0_0", 3, 8'd0, 8'd0, 2'b00);
        run_cmp("p3_255_0", 3, 8'd255, 8'd0, 2'b01);
        run_cmp("p3_0_255", 3, 8'd0, 8'd255, 2'b10);

        // Reset during cycle 4 of SHIFT: outputs clear at once, no done follows.
        bus_if.a_in[1*W +: W] = 8'hFF;
        bus_if.b_in[1*W +: W] = 8'h00;
        bus_if.req = 4'b0010;
        @(negedge clk);
        chk("mid_grant", 32'(bus_if.grant), 32'b0010);
        bus_if.req = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
        chk("mid_rst_done_id", 32'(bus_if.done_id), 32'd0);
        chk("mid_rst_result", 32'(bus_if.result), 32'd0);
        chk("mid_rst_grant", 32'(bus_if.grant), 32'd0);
        begin : rst_hold
            int dones;
            dones = 0;
            repeat (8) begin
                @(negedge clk);
                if (bus_if.done) dones++;
            end
            chk("mid_rst_no_done", 32'(dones), 32'd0);
        end
        rst_n = 1'b1;
        run_cmp("post_rst_p2", 2, 8'hF0, 8'h3F, 2'b10);

        // Captured operand must win over a later change on the bus.
        bus_if.a_in[0 +: W] = 8'h0F;
        bus_if.b_in[0 +: W] = 8'h07;
        bus_if.req = 4'b0001;
        @(negedge clk);
        chk("stab_grant", 32'(bus_if.grant), 32'b0001);
        bus_if.a_in[0 +: W] = 8'h00;
        bus_if.req = '0;
        repeat (8) @(negedge clk);
        chk("stab_done", 32'(bus_if.done), 32'd1);
        chk("stab_result", 32'(bus_if.result), 32'b01);
        @(negedge clk);

        // Fairness: requests held through reset, then port 1 joins late.
        rst_n       = 1'b0;
        bus_if.a_in = '0;
        bus_if.b_in = '0;
        bus_if.req  = 4'b0101;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int g = 0; g < 7; g++) begin : win
            int extra;
            int clash;
            extra = 0;
            clash = 0;
            for (int o = 0; o < 10; o++) begin
                @(negedge clk);
                if (bus_if.grant != '0 && bus_if.done) clash++;
                if (o == 0)
                    chk($sformatf("fair%0d_grant", g), 32'(bus_if.grant), 32'(1) << exp_g[g]);
                else if (bus_if.grant != '0)
                    extra++;
                if (o == 8) begin
                    chk($sformatf("fair%0d_done", g), 32'(bus_if.done), 32'd1);
                    chk($sformatf("fair%0d_done_id", g), 32'(bus_if.done_id), 32'(exp_g[g]));
                    if (g == 6) bus_if.req = '0;
                end
                if (g == 3 && o == 4) bus_if.req = 4'b0111;
            end
            chk($sformatf("fair%0d_extra_grants", g), 32'(extra), 32'd0);
            chk($sformatf("fair%0d_grant_done_clash", g), 32'(clash), 32'd0);
        end
        repeat (2) @(negedge clk);
        chk("final_idle_grant", 32'(bus_if.grant), 32'd0);
        chk("final_idle_busy", 32'(bus_if.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
